// File: rtl/alarm_fsm_if.sv
// Purpose: signal bundle between the alarm controller and its environment
//          (vehicle inputs, delay programming port, countdown-timer handshake,
//          siren/LED/state display outputs).
// Signals:
//   ignition, door_driver, door_pass      vehicle inputs (synchronous, debounced)
//   prog_en, prog_sel[1:0], prog_value[3:0]  delay register write port
//   waited                                timer expiry flag from the countdown timer
//   timer_load, timer_en, t_default[3:0]  countdown timer control
//   siren, status_led, state_code[2:0]    indicators
// Modports: master = environment/bench side, slave = alarm_fsm side.
interface alarm_fsm_if;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       prog_en;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic       waited;
    logic       timer_load;
    logic       timer_en;
    logic [3:0] t_default;
    logic       siren;
    logic       status_led;
    logic [2:0] state_code;

    modport master (
        output ignition, door_driver, door_pass, prog_en, prog_sel, prog_value, waited,
        input  timer_load, timer_en, t_default, siren, status_led, state_code
    );

    modport slave (
        input  ignition, door_driver, door_pass, prog_en, prog_sel, prog_value, waited,
        output timer_load, timer_en, t_default, siren, status_led, state_code
    );
endinterface

// File: rtl/alarm_fsm.sv
// Purpose: anti-theft alarm controller. Sequences arm/trigger/siren/disarm
//          modes, drives the countdown timer (load/en/t_default), holds the
//          four programmable delays and drives the siren and status LED.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    alarm_fsm_if.slave: vehicle inputs, programming port, timer
//          handshake and indicator outputs (all outputs registered)
module alarm_fsm #(
    parameter logic [3:0]  T_ARM_DEF  = 4'd6,
    parameter logic [3:0]  T_DRV_DEF  = 4'd8,
    parameter logic [3:0]  T_PAS_DEF  = 4'd15,
    parameter logic [3:0]  T_ALM_DEF  = 4'd10,
    parameter int unsigned BLINK_HALF = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    alarm_fsm_if.slave  bus
);
    localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [1:0] SEL_ARM = 2'd0;
    localparam logic [1:0] SEL_DRV = 2'd1;
    localparam logic [1:0] SEL_PAS = 2'd2;
    localparam logic [1:0] SEL_ALM = 2'd3;

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIGGERED  = 3'd1,
        SOUND      = 3'd2,
        HOLD       = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DELAY  = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic               load_d;
    logic [1:0]         sel_d;
    logic               timer_load_q, timer_en_q, siren_q, led_q;
    logic               timer_en_d, siren_d, led_d;
    logic [3:0]         t_default_q, t_default_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         dly_q [4];
    logic               any_door, no_door, wait_ok;

    assign any_door = bus.door_driver | bus.door_pass;
    assign no_door  = ~any_door;
    // The expiry flag may still be stale in the cycle the timer is being loaded.
    assign wait_ok  = bus.waited & ~timer_load_q;

    // State, delay registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARMED;
            timer_load_q <= 1'b0;
            timer_en_q   <= 1'b0;
            t_default_q  <= 4'd0;
            siren_q      <= 1'b0;
            led_q        <= 1'b1;
            cnt_q        <= '0;
            dly_q[0]     <= T_ARM_DEF;
            dly_q[1]     <= T_DRV_DEF;
            dly_q[2]     <= T_PAS_DEF;
            dly_q[3]     <= T_ALM_DEF;
        end else begin
            state_q      <= state_d;
            timer_load_q <= load_d;
            timer_en_q   <= timer_en_d;
            t_default_q  <= t_default_d;
            siren_q      <= siren_d;
            led_q        <= led_d;
            cnt_q        <= cnt_d;
            // A zero delay is meaningless and is dropped.
            if (bus.prog_en && (bus.prog_value != 4'd0)) begin
                dly_q[bus.prog_sel] <= bus.prog_value;
            end
        end
    end

    // Next state, plus timer load request and which delay to load.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        sel_d   = SEL_ARM;
        case (state_q)
            ARMED: begin
                if (bus.ignition) begin
                    state_d = DISARMED;
                end else if (bus.door_driver) begin
                    state_d = TRIGGERED;
                    load_d  = 1'b1;
                    sel_d   = SEL_DRV;
                end else if (bus.door_pass) begin
                    state_d = TRIGGERED;
                    load_d  = 1'b1;
                    sel_d   = SEL_PAS;
                end
            end
            TRIGGERED: begin
                if (bus.ignition)  state_d = DISARMED;
                else if (wait_ok)  state_d = SOUND;
            end
            SOUND: begin
                if (bus.ignition) begin
                    state_d = DISARMED;
                end else if (no_door) begin
                    state_d = HOLD;
                    load_d  = 1'b1;
                    sel_d   = SEL_ALM;
                end
            end
            HOLD: begin
                if (bus.ignition)  state_d = DISARMED;
                else if (any_door) state_d = SOUND;
                else if (wait_ok)  state_d = ARMED;
            end
            DISARMED: begin
                if (!bus.ignition) state_d = WAIT_OPEN;
            end
            WAIT_OPEN: begin
                if (bus.ignition)         state_d = DISARMED;
                else if (bus.door_driver) state_d = WAIT_CLOSE;
            end
            WAIT_CLOSE: begin
                if (bus.ignition) begin
                    state_d = DISARMED;
                end else if (no_door) begin
                    state_d = ARM_DELAY;
                    load_d  = 1'b1;
                    sel_d   = SEL_ARM;
                end
            end
            ARM_DELAY: begin
                if (bus.ignition)  state_d = DISARMED;
                else if (any_door) state_d = WAIT_CLOSE;
                else if (wait_ok)  state_d = ARMED;
            end
            default: state_d = ARMED;
        endcase
    end

    // Registered output values derived from the upcoming state.
    always_comb begin
        timer_en_d  = 1'b0;
        siren_d     = 1'b0;
        led_d       = 1'b0;
        cnt_d       = '0;
        // Reads the pre-write register, so a same-cycle write loads the old value.
        t_default_d = load_d ? dly_q[sel_d] : t_default_q;
        case (state_d)
            TRIGGERED, ARM_DELAY: timer_en_d = 1'b1;
            HOLD: begin
                timer_en_d = 1'b1;
                siren_d    = 1'b1;
            end
            SOUND:   siren_d = 1'b1;
            default: ;
        endcase
        case (state_d)
            ARMED: begin
                if (state_q != ARMED) begin
                    led_d = 1'b1;
                end else if (cnt_q == CNT_W'(BLINK_HALF - 1)) begin
                    led_d = ~led_q;
                end else begin
                    led_d = led_q;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TRIGGERED, SOUND, HOLD: led_d = 1'b1;
            default: led_d = 1'b0;
        endcase
    end

    assign bus.timer_load = timer_load_q;
    assign bus.timer_en   = timer_en_q;
    assign bus.t_default  = t_default_q;
    assign bus.siren      = siren_q;
    assign bus.status_led = led_q;
    assign bus.state_code = state_q;
endmodule
